// File: rtl/lcd_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_read_engine
//  Description : HD44780-class LCD read-side engine. Runs one RW=1 bus cycle
//                to fetch the busy flag / address counter (RS=0) or a data
//                RAM byte (RS=1). The top level grants the RS/RW/E pin mux to
//                this block while rd_busy is high.
//                Optional feature macro: LCD_RD_POLL_EN (busy-flag polling).
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_read_engine #(
    parameter int T_SETUP   = 1,
    parameter int T_EN_HIGH = 2,
    parameter int T_EN_LOW  = 2,
    parameter int POLL_MAX  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       rd_rs,
    output logic       rd_busy,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       bf,
    output logic [6:0] ac,
    input  logic [7:0] lcd_db_in,
    output logic       lcd_db_oe,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       poll_tmo
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_EN_HI = 3'd2,
        S_EN_LO = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Last cycle index of each timed phase (phase counter starts at 0).
    localparam logic [7:0] c_SETUP_LAST = 8'(T_SETUP - 1);
    localparam logic [7:0] c_EN_HI_LAST = 8'(T_EN_HIGH - 1);
    localparam logic [7:0] c_EN_LO_LAST = 8'(T_EN_LOW - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rs_q;
    logic [7:0] rd_data_q;
    logic       bf_q;
    logic [6:0] ac_q;

    logic w_accept;
    logic w_sample;
    logic w_repeat;   // current DONE loops straight back into another poll read
    logic w_tmo;      // current poll ended by exhausting its read budget

    // A request is taken in IDLE, or on the edge ending a final DONE so that
    // a held request runs back-to-back without an idle gap.
    assign w_accept = rd_req && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && !w_repeat));

    // The bus is sampled on the edge that ends the last E-high cycle.
    assign w_sample = (state_q == S_EN_HI) && (cnt_q == c_EN_HI_LAST);

`ifdef LCD_RD_POLL_EN
    localparam logic [7:0] c_POLL_LAST = 8'(POLL_MAX - 1);

    logic [7:0] poll_cnt_q;
    logic       more_q;
    logic       tmo_q;

    // Poll bookkeeping: decide at each sample whether another BF read follows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            poll_cnt_q <= 8'd0;
            more_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else if (w_accept) begin
            poll_cnt_q <= 8'd0;
            more_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else if (w_sample) begin
            poll_cnt_q <= poll_cnt_q + 8'd1;
            if (!rs_q && lcd_db_in[7]) begin
                // poll_cnt_q counts reads completed before this one
                more_q <= (poll_cnt_q < c_POLL_LAST);
                tmo_q  <= (poll_cnt_q >= c_POLL_LAST);
            end else begin
                more_q <= 1'b0;
                tmo_q  <= 1'b0;
            end
        end
    end

    assign w_repeat = more_q;
    assign w_tmo    = tmo_q;
`else
    assign w_repeat = 1'b0;
    assign w_tmo    = 1'b0;
`endif

    // State and phase counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the read type at acceptance; it stays fixed for the whole poll.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rs_q <= 1'b0;
        end else if (w_accept) begin
            rs_q <= rd_rs;
        end
    end

    // Result registers. A reset that lands mid-transaction aborts it but
    // leaves the previous result visible; a reset seen while idle (power-up
    // reset is held for at least two cycles) clears the results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_IDLE) begin
                rd_data_q <= 8'd0;
                bf_q      <= 1'b0;
                ac_q      <= 7'd0;
            end
        end else if (w_sample) begin
            rd_data_q <= lcd_db_in;
            if (!rs_q) begin
                bf_q <= lcd_db_in[7];
                ac_q <= lcd_db_in[6:0];
            end
        end
    end

    // Next-state logic; the phase counter restarts at 0 on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (w_accept) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (cnt_q == c_SETUP_LAST) begin
                    state_d = S_EN_HI;
                    cnt_d   = 8'd0;
                end
            end
            S_EN_HI: begin
                if (cnt_q == c_EN_HI_LAST) begin
                    state_d = S_EN_LO;
                    cnt_d   = 8'd0;
                end
            end
            S_EN_LO: begin
                if (cnt_q == c_EN_LO_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                end
            end
            S_DONE: begin
                cnt_d = 8'd0;
                if (w_repeat || w_accept) state_d = S_SETUP;
                else                      state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Pin and status decode from the registered state.
    always_comb begin
        rd_busy  = 1'b0;
        rd_valid = 1'b0;
        poll_tmo = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_en   = 1'b0;
        case (state_q)
            S_SETUP: begin
                rd_busy = 1'b1;
                lcd_rw  = 1'b1;
                lcd_rs  = rs_q;
            end
            S_EN_HI: begin
                rd_busy = 1'b1;
                lcd_rw  = 1'b1;
                lcd_rs  = rs_q;
                lcd_en  = 1'b1;
            end
            S_EN_LO: begin
                rd_busy = 1'b1;
                lcd_rw  = 1'b1;
                lcd_rs  = rs_q;
            end
            S_DONE: begin
                rd_busy  = 1'b1;
                rd_valid = !w_repeat;
                poll_tmo = !w_repeat && w_tmo;
            end
            default: ;
        endcase
    end

    assign lcd_db_oe = 1'b0;
    assign rd_data   = rd_data_q;
    assign bf        = bf_q;
    assign ac        = ac_q;

endmodule
`default_nettype wire
